// File: rtl/bsg_scan_pkg.sv
// bsg_scan_pkg
//   Shared types and helpers for the streaming segmented prefix-scan engine.
//   scan_op_e      : reduction operator carried by a segment
//   scan_identity  : identity element of an operator (fill / segment start)
//   scan_op_decode : maps the raw 2-bit op field onto scan_op_e (11 -> OR)
package bsg_scan_pkg;

    typedef enum logic [1:0] {
        e_scan_or  = 2'b00,
        e_scan_and = 2'b01,
        e_scan_xor = 2'b10
    } scan_op_e;

    function automatic logic scan_identity(scan_op_e op);
        return (op == e_scan_and);
    endfunction

    // The reserved encoding folds onto OR so an unexpected op still gives a
    // well-defined, monotone result.
    function automatic scan_op_e scan_op_decode(logic [1:0] raw);
        scan_op_e op;
        case (raw)
            2'b01:   op = e_scan_and;
            2'b10:   op = e_scan_xor;
            default: op = e_scan_or;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/bsg_scan_seg_core.sv
// bsg_scan_seg_core
//   Combinational log-depth (Kogge-Stone style) prefix network for one beat.
//   Parameters:
//     width_p    : bits per beat
//     lo_to_hi_p : 1 = prefix grows from bit 0 upward, 0 = from the MSB down
//   Ports:
//     data_i  : beat to scan
//     op_i    : reduction operator
//     carry_i : running reduction of the earlier beats of the segment
//     data_o  : data_o[j] = carry_i op (all bits from the start edge up to j)
module bsg_scan_seg_core
    import bsg_scan_pkg::*;
#(
    parameter int width_p    = 8,
    parameter bit lo_to_hi_p = 1'b1
) (
    input  logic [width_p-1:0] data_i,
    input  scan_op_e           op_i,
    input  logic               carry_i,
    output logic [width_p-1:0] data_o
);

    localparam int levels_lp = (width_p > 1) ? $clog2(width_p) : 0;

    function automatic logic [width_p-1:0] combine(scan_op_e op,
                                                   logic [width_p-1:0] a,
                                                   logic [width_p-1:0] b);
        logic [width_p-1:0] r;
        case (op)
            e_scan_and: r = a & b;
            e_scan_xor: r = a ^ b;
            default:    r = a | b;
        endcase
        return r;
    endfunction

    function automatic logic [width_p-1:0] reverse(logic [width_p-1:0] v);
        logic [width_p-1:0] r;
        for (int j = 0; j < width_p; j++) begin
            r[j] = v[width_p-1-j];
        end
        return r;
    endfunction

    always_comb begin
        logic [width_p-1:0] row;
        logic [width_p-1:0] shifted;
        logic [width_p-1:0] fill_mask;
        logic [width_p-1:0] ones;

        ones      = '1;
        shifted   = '0;
        fill_mask = '0;

        // The network is built once for the upward direction; the downward
        // variant mirrors the bits on the way in and out.
        row = lo_to_hi_p ? data_i : reverse(data_i);

        // Each level combines with the partial result 2^k positions below.
        // Positions that fall off the low edge see the operator identity, so
        // the carry is never folded in more than once (matters for XOR).
        for (int k = 0; k < levels_lp; k++) begin
            fill_mask = ~(ones << (1 << k));
            shifted   = (row << (1 << k)) |
                        (scan_identity(op_i) ? fill_mask : '0);
            row       = combine(op_i, row, shifted);
        end

        // Segment carry enters every position in a single final combine.
        row    = combine(op_i, row, {width_p{carry_i}});
        data_o = lo_to_hi_p ? row : reverse(row);
    end

endmodule

// File: rtl/bsg_scan_stream.sv
// bsg_scan_stream
//   Streaming segmented prefix scan (OR / AND / XOR) over width_p-bit beats.
//   The running reduction is carried across the beats of a segment; a
//   segment ends with last_i. One registered output stage, full throughput.
//   Parameters:
//     width_p     : bits per beat (>= 1)
//     lo_to_hi_p  : scan direction, 1 = from bit 0 upward
//     max_beats_p : beats per segment before overflow_o is flagged
//   Ports:
//     clk_i, reset_i    : clock, synchronous active-high reset
//     v_i / ready_o     : input beat handshake
//     data_i, op_i      : beat and operator (op_i used on a segment's first beat)
//     last_i            : beat closes its segment
//     v_o / yumi_i      : output handshake (yumi_i only while v_o)
//     data_o            : scanned beat
//     last_o            : last_i of the output beat
//     beat_idx_o        : 0-based position of the beat in its segment
//     carry_o           : segment reduction up to and including this beat
//     overflow_o        : sticky, a segment ran past max_beats_p beats
module bsg_scan_stream
    import bsg_scan_pkg::*;
#(
    parameter int  width_p     = 8,
    parameter bit  lo_to_hi_p  = 1'b1,
    parameter int  max_beats_p = 16,
    localparam int idx_w_lp    = (max_beats_p > 1) ? $clog2(max_beats_p) : 1
) (
    input  logic                clk_i,
    input  logic                reset_i,

    input  logic                v_i,
    output logic                ready_o,
    input  logic [width_p-1:0]  data_i,
    input  logic [1:0]          op_i,
    input  logic                last_i,

    output logic                v_o,
    input  logic                yumi_i,
    output logic [width_p-1:0]  data_o,
    output logic                last_o,
    output logic [idx_w_lp-1:0] beat_idx_o,
    output logic                carry_o,
    output logic                overflow_o
);

    localparam logic [idx_w_lp-1:0] cnt_max_lp = idx_w_lp'(max_beats_p - 1);

    // Segment state
    logic                in_seg_r;
    scan_op_e            op_r;
    logic                carry_r;
    logic [idx_w_lp-1:0] cnt_r;
    logic                overflow_r;

    // Output register
    logic                vld_p1;
    logic [width_p-1:0]  data_p1;
    logic                last_p1;
    logic [idx_w_lp-1:0] idx_p1;
    logic                carry_p1;

    logic                accept;
    scan_op_e            op_eff;
    logic                carry_in;
    logic [width_p-1:0]  scan_data;
    logic                scan_top;

    // ---- stage p0: accept and scan the incoming beat ----
    // The output register can take a new beat when empty or when its current
    // beat is being consumed this same cycle.
    assign ready_o = ~vld_p1 | yumi_i;
    assign accept  = v_i & ready_o;

    assign op_eff   = in_seg_r ? op_r : scan_op_decode(op_i);
    assign carry_in = in_seg_r ? carry_r : scan_identity(op_eff);

    bsg_scan_seg_core #(
        .width_p    (width_p),
        .lo_to_hi_p (lo_to_hi_p)
    ) core (
        .data_i  (data_i),
        .op_i    (op_eff),
        .carry_i (carry_in),
        .data_o  (scan_data)
    );

    // The bit where the prefix ends holds the reduction of the whole beat.
    assign scan_top = lo_to_hi_p ? scan_data[width_p-1] : scan_data[0];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            in_seg_r   <= 1'b0;
            op_r       <= e_scan_or;
            carry_r    <= 1'b0;
            cnt_r      <= '0;
            overflow_r <= 1'b0;
        end else if (accept) begin
            op_r <= op_eff;
            if (last_i) begin
                in_seg_r <= 1'b0;
                carry_r  <= 1'b0;
                cnt_r    <= '0;
            end else begin
                in_seg_r <= 1'b1;
                carry_r  <= scan_top;
                // Past the limit the index sticks at its maximum while the
                // scan itself keeps running.
                if (cnt_r == cnt_max_lp) begin
                    overflow_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + idx_w_lp'(1);
                end
            end
        end
    end

    // ---- stage p1: registered output, held while stalled ----
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            last_p1  <= 1'b0;
            idx_p1   <= '0;
            carry_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            data_p1  <= scan_data;
            last_p1  <= last_i;
            idx_p1   <= cnt_r;
            carry_p1 <= scan_top;
        end else if (yumi_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign v_o        = vld_p1;
    assign data_o     = data_p1;
    assign last_o     = last_p1;
    assign beat_idx_o = idx_p1;
    assign carry_o    = carry_p1;
    assign overflow_o = overflow_r;

endmodule

// File: tb/tb_bsg_scan_stream.sv
// tb_bsg_scan_stream
//   Two instances (upward and downward scan) share one input stream; every
//   accepted beat pushes its expected result for each instance, and results
//   are popped and compared as the instances deliver them.
module tb_bsg_scan_stream;

    localparam int W  = 4;
    localparam int MB = 4;
    localparam int IW = 2;

    typedef struct {
        logic [W-1:0]  data;
        logic          last;
        logic [IW-1:0] idx;
        logic          carry;
        logic          ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i;
    logic          v_i;
    logic [W-1:0]  data_i;
    logic [1:0]    op_i;
    logic          last_i;
    logic          yumi_en;

    logic          ready_a, v_a, last_a, carry_a, ovf_a, yumi_a;
    logic [W-1:0]  data_a;
    logic [IW-1:0] idx_a;
    logic          ready_b, v_b, last_b, carry_b, ovf_b, yumi_b;
    logic [W-1:0]  data_b;
    logic [IW-1:0] idx_b;

    assign yumi_a = yumi_en & v_a;
    assign yumi_b = yumi_en & v_b;

    bsg_scan_stream #(.width_p(W), .lo_to_hi_p(1'b1), .max_beats_p(MB)) dut_a (
        .clk_i(clk), .reset_i(reset_i),
        .v_i(v_i), .ready_o(ready_a), .data_i(data_i), .op_i(op_i), .last_i(last_i),
        .v_o(v_a), .yumi_i(yumi_a), .data_o(data_a), .last_o(last_a),
        .beat_idx_o(idx_a), .carry_o(carry_a), .overflow_o(ovf_a)
    );

    bsg_scan_stream #(.width_p(W), .lo_to_hi_p(1'b0), .max_beats_p(MB)) dut_b (
        .clk_i(clk), .reset_i(reset_i),
        .v_i(v_i), .ready_o(ready_b), .data_i(data_i), .op_i(op_i), .last_i(last_i),
        .v_o(v_b), .yumi_i(yumi_b), .data_o(data_b), .last_o(last_b),
        .beat_idx_o(idx_b), .carry_o(carry_b), .overflow_o(ovf_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    exp_t       q_a[$];
    exp_t       q_b[$];
    logic       m_in_seg;
    logic [1:0] m_op;
    logic       m_ca, m_cb;
    int         m_cnt;
    logic       m_ovf;

    function automatic logic [W-1:0] model_scan(logic [W-1:0] d, logic [1:0] op,
                                                logic cin, bit up);
        logic [W-1:0] r;
        logic acc;
        acc = cin;
        r   = '0;
        for (int i = 0; i < W; i++) begin
            int j;
            j = up ? i : W - 1 - i;
            case (op)
                2'b01:   acc = acc & d[j];
                2'b10:   acc = acc ^ d[j];
                default: acc = acc | d[j];
            endcase
            r[j] = acc;
        end
        return r;
    endfunction

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        m_in_seg = 1'b0;
        m_op     = 2'b00;
        m_ca     = 1'b0;
        m_cb     = 1'b0;
        m_cnt    = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_accept(input logic [W-1:0] d, input logic [1:0] op, input logic last);
        logic [1:0] op_eff;
        logic       cin_a, cin_b;
        exp_t       ea, eb;
        op_eff = m_in_seg ? m_op : ((op == 2'b11) ? 2'b00 : op);
        cin_a  = m_in_seg ? m_ca : (op_eff == 2'b01);
        cin_b  = m_in_seg ? m_cb : (op_eff == 2'b01);
        ea.data  = model_scan(d, op_eff, cin_a, 1'b1);
        eb.data  = model_scan(d, op_eff, cin_b, 1'b0);
        ea.carry = ea.data[W-1];
        eb.carry = eb.data[0];
        ea.last  = last;
        eb.last  = last;
        ea.idx   = IW'(m_cnt);
        eb.idx   = IW'(m_cnt);
        m_op     = op_eff;
        if (last) begin
            m_in_seg = 1'b0;
            m_cnt    = 0;
        end else begin
            m_in_seg = 1'b1;
            m_ca     = ea.carry;
            m_cb     = eb.carry;
            if (m_cnt == MB - 1) m_ovf = 1'b1;
            else                 m_cnt++;
        end
        ea.ovf = m_ovf;
        eb.ovf = m_ovf;
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (!reset_i && yumi_en) begin
            if (v_a) begin
                if (q_a.size() == 0) begin
                    check_eq("a_unexpected_beat", 32'(data_a), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    check_eq("a_data",  32'(data_a),  32'(e.data));
                    check_eq("a_last",  32'(last_a),  32'(e.last));
                    check_eq("a_idx",   32'(idx_a),   32'(e.idx));
                    check_eq("a_carry", 32'(carry_a), 32'(e.carry));
                    check_eq("a_ovf",   32'(ovf_a),   32'(e.ovf));
                end
            end
            if (v_b) begin
                if (q_b.size() == 0) begin
                    check_eq("b_unexpected_beat", 32'(data_b), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    check_eq("b_data",  32'(data_b),  32'(e.data));
                    check_eq("b_last",  32'(last_b),  32'(e.last));
                    check_eq("b_idx",   32'(idx_b),   32'(e.idx));
                    check_eq("b_carry", 32'(carry_b), 32'(e.carry));
                    check_eq("b_ovf",   32'(ovf_b),   32'(e.ovf));
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+2; returns at posedge+2 after the beat is accepted.
    task automatic send(input logic [W-1:0] d, input logic [1:0] op, input logic last);
        int n;
        n      = 0;
        v_i    = 1'b1;
        data_i = d;
        op_i   = op;
        last_i = last;
        while (!ready_a && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check_eq("ready_wait", 32'(ready_a), 32'd1);
        if (ready_a) model_accept(d, op, last);
        @(posedge clk); #2;
        v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    initial begin
        int c0;
        reset_i = 1'b1;
        v_i     = 1'b0;
        data_i  = '0;
        op_i    = 2'b00;
        last_i  = 1'b0;
        yumi_en = 1'b0;
        model_reset();
        idle(3);
        reset_i = 1'b0;

        // reset state
        check_eq("rst_v",     32'(v_a),     32'd0);
        check_eq("rst_data",  32'(data_a),  32'd0);
        check_eq("rst_last",  32'(last_a),  32'd0);
        check_eq("rst_idx",   32'(idx_a),   32'd0);
        check_eq("rst_carry", 32'(carry_a), 32'd0);
        check_eq("rst_ovf",   32'(ovf_a),   32'd0);
        check_eq("rst_ready", 32'(ready_a), 32'd1);
        check_eq("rst_v_b",   32'(v_b),     32'd0);
        yumi_en = 1'b1;

        // single OR beat, two-beat OR segment with carry
        send(4'b0010, 2'b00, 1'b1);
        send(4'b0010, 2'b00, 1'b0);
        send(4'b0000, 2'b01, 1'b1);
        // AND then XOR: carry back to identity, op re-sampled
        send(4'b0111, 2'b01, 1'b1);
        send(4'b1111, 2'b10, 1'b1);
        // reserved op behaves as OR; multi-beat XOR and AND segments
        send(4'b0100, 2'b11, 1'b1);
        send(4'b1011, 2'b10, 1'b0);
        send(4'b0110, 2'b00, 1'b0);
        send(4'b0001, 2'b01, 1'b1);
        send(4'b1110, 2'b01, 1'b0);
        send(4'b1111, 2'b10, 1'b1);
        idle(3);

        // backpressure: output held, second beat waits
        yumi_en = 1'b0;
        send(4'b1001, 2'b10, 1'b1);
        fork
            send(4'b0101, 2'b00, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_eq("bp_ready", 32'(ready_a), 32'd0);
                    check_eq("bp_v",     32'(v_a),     32'd1);
                    check_eq("bp_data",  32'(data_a),  32'(q_a[0].data));
                end
                @(posedge clk); #1;
                yumi_en = 1'b1;
            end
        join
        idle(3);

        // 8-beat stream at full throughput (segments of 3, 3, 2)
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send(W'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 (i == 2) || (i == 5) || (i == 7));
        end
        check_eq("stream_cycles", 32'(cyc - c0), 32'd8);
        idle(3);

        // overflow: 5 beats in one segment with max 4
        check_eq("pre_ovf", 32'(ovf_a), 32'd0);
        for (int i = 0; i < 5; i++) begin
            send(W'($urandom_range(0, 15)), 2'b10, i == 4);
        end
        idle(3);
        check_eq("ovf_sticky", 32'(ovf_a), 32'd1);
        send(4'b0011, 2'b00, 1'b1);
        idle(3);
        check_eq("ovf_sticky2", 32'(ovf_b), 32'd1);

        // reset mid-segment with an output beat pending
        send(4'b1000, 2'b00, 1'b0);
        send(4'b1000, 2'b00, 1'b0);
        yumi_en = 1'b0;
        reset_i = 1'b1;
        model_reset();
        idle(1);
        reset_i = 1'b0;
        check_eq("mid_rst_v",    32'(v_a),    32'd0);
        check_eq("mid_rst_ovf",  32'(ovf_a),  32'd0);
        check_eq("mid_rst_data", 32'(data_b), 32'd0);
        yumi_en = 1'b1;
        send(4'b1111, 2'b01, 1'b1);
        idle(4);

        check_eq("q_a_empty", 32'(q_a.size()), 32'd0);
        check_eq("q_b_empty", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
